mtx_vliw_seq: RTL and testbench
===============================

# mtx_vliw_seq

VLIW bundle sequencer for the ternary matrix/vector unit. It accepts one `vliw_inst_t` bundle (four `op_t` slots) at a time and issues the slots in order, op1 first, to the execution datapath over a valid/ready issue port. It waits for a completion strobe after each issued op, screens out illegal opcodes, and guards each op with a completion watchdog. It sits between the instruction fetch buffer and the M0/V0/V1 execution unit.

## Interface
- `TIMEOUT`, default 256: maximum cycles in WAIT without `exec_done`; 0 disables the watchdog.
- `clk`  in  1  clock. One clock domain; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `inst_valid`  in  1  a bundle is offered.
- `inst_ready`  out  1  the sequencer can accept a bundle. High only in IDLE.
- `inst`  in  20  `vliw_inst_t`. op1 is `[19:15]`, op2 is `[14:10]`, op3 is `[9:5]`, op4 is `[4:0]`.
- `op_valid`  out  1  an op is presented to the execution unit.
- `op_ready`  in  1  the execution unit accepts the op.
- `op`  out  5  `op_t` being issued.
- `op_slot`  out  2  slot index of `op`, 0 to 3.
- `exec_done`  in  1  single-cycle pulse: the accepted op has completed.
- `bundle_done`  out  1  one-cycle pulse when a bundle retires.
- `busy`  out  1  high in any state other than IDLE.
- `err_inv`  out  1  sticky flag: an illegal opcode was seen.
- `err_to`  out  1  sticky flag: the watchdog expired.
- `err_clr`  in  1  clears both sticky flags.

## Operation
- **States and transitions**
  - IDLE: a bundle is accepted on `inst_valid & inst_ready`. Latch the bundle, set slot=0, go to ISSUE.
  - ISSUE: evaluate the current slot.
    - Legal non-NOP op: drive `op_valid=1`, `op`, `op_slot`. On `op_ready`, go to WAIT.
    - NOP or illegal op: `op_valid=0` and the slot is consumed. An illegal op also sets `err_inv`.
  - WAIT: on `exec_done`, advance the slot. If slot 3 just finished, go to DONE; otherwise go to ISSUE.
  - DONE: `bundle_done=1` for one cycle, then go to IDLE.
- **Legal encodings:** 0x00–0x03 and 0x08–0x16. Every other 5-bit value is illegal.
- **Issue port stability:** while `op_valid=1` and `op_ready=0`, `op` and `op_slot` stay constant. `op_valid` does not drop until the op is accepted.
- **`exec_done` outside WAIT** is ignored.
- **Watchdog**
  - The counter is cleared on entry to WAIT and counts every cycle spent in WAIT.
  - If it reaches `TIMEOUT` before `exec_done` arrives, set `err_to` and go to DONE; the remaining slots are abandoned.
  - If `exec_done` arrives in the same cycle the counter reaches `TIMEOUT`, `exec_done` wins and `err_to` stays clear.
- **Sticky flags**
  - `err_clr` clears both flags.
  - If `err_clr` and a new error occur in the same cycle, the set wins.
- **Reset**
  - State returns to IDLE.
  - `op_valid`, `bundle_done`, `busy`, `err_inv`, `err_to` = 0; `op` = NOP; `op_slot` = 0.
  - `inst_ready` = 0 while `rst` is high and 1 in the first cycle after release.
  - Reset during ISSUE or WAIT abandons the bundle with no `bundle_done` pulse.

## Timing
- All outputs are registered, except `inst_ready` and `busy`, which are decoded from the state register.
- Accept at cycle T: the first slot is in ISSUE at T+1.
- Op accepted at cycle A: earliest `exec_done` is A+1; the next slot is in ISSUE at the cycle after `exec_done`.
- Without skipping, each NOP or illegal slot costs exactly one ISSUE cycle.
- DONE lasts one cycle; `inst_ready` rises the following cycle.
- Minimum bundle with 4 ops, `op_ready=1`, and `exec_done` at A+1: `bundle_done` at T+9.

## Configuration
- Macro `MTX_SEQ_NOP_SKIP_EN`.
- **Defined:** NOP and illegal slots take zero cycles.
  - On entering ISSUE and on each slot advance, the slot pointer jumps to the next legal non-NOP slot.
  - If no such slot remains, the sequencer goes directly to DONE.
  - An all-NOP bundle accepted at T pulses `bundle_done` at T+1.
  - `err_inv` is still set for skipped illegal slots.
- **Undefined:** one ISSUE cycle per NOP or illegal slot, as described under Operation.

## Test plan
- **Basic sequencing:** `inst=0x10281` (VADD_01, NOP, VRELU, MVMUL), `op_ready=1`, `exec_done` one cycle after each accept, accepted at T.
  - Without the macro: ops issued at T+1, T+4, T+6; `op_slot` = 0, 2, 3; `bundle_done` at T+8.
  - With the macro: `bundle_done` at T+7.
- **Illegal opcode:** op2=0x1F, other slots VSQR → `err_inv`=1, 0x1F is never driven on `op`, three VSQR ops issued. Then `err_clr` for one cycle → `err_inv`=0.
- **Backpressure:** hold `op_ready=0` for 3 cycles during slot 0 = LD_V0 → `op_valid`=1, `op`=0x08, `op_slot`=0 held stable; WAIT entered the cycle after `op_ready` rises.
- **Watchdog:** `TIMEOUT=4`, `exec_done` never asserted → `err_to`=1 after 4 WAIT cycles, `bundle_done` pulses next, slots 1–3 never issued, `inst_ready` high the cycle after.
- **Reset mid-bundle:** `rst` asserted while in WAIT on slot 1 → all outputs at reset values the next cycle, no `bundle_done`; a new bundle is accepted after release.
- **Stray completion:** `exec_done` pulsed in IDLE and in ISSUE → no state change and no `bundle_done`.

Source files
------------

// File: rtl/mtx_vliw_seq.sv
// VLIW bundle sequencer: issues four op slots in order, waits for completion, watchdog per op.
// Define MTX_SEQ_NOP_SKIP_EN to let NOP and illegal slots take zero cycles.
module mtx_vliw_seq #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [19:0] inst,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [4:0]  op,
    output logic [1:0]  op_slot,
    input  logic        exec_done,
    output logic        bundle_done,
    output logic        busy,
    output logic        err_inv,
    output logic        err_to,
    input  logic        err_clr
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W:0] WD_LIM = (WD_W + 1)'(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [19:0]     bundle_q, bundle_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [WD_W:0]   wd_inc;
    logic            op_valid_q, op_valid_d;
    logic [4:0]      op_q, op_d;
    logic [1:0]      op_slot_q, op_slot_d;
    logic            bundle_done_q, bundle_done_d;
    logic            err_inv_q, err_inv_d;
    logic            err_to_q, err_to_d;
    logic            set_inv, set_to, accept;
    logic [4:0]      slot_op [4];
    logic [3:0]      exec_m, ill_m;

    assign inst_ready = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign accept     = inst_valid && inst_ready;
    assign bundle_d   = accept ? inst : bundle_q;

    // Slot decode always looks at the bundle that will be current next cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign slot_op[gi] = bundle_d[19 - 5*gi -: 5];
        assign ill_m[gi]   = !((slot_op[gi] <= 5'h03) ||
                               ((slot_op[gi] >= 5'h08) && (slot_op[gi] <= 5'h16)));
        assign exec_m[gi]  = !ill_m[gi] && (slot_op[gi] != OP_NOP);
    end

`ifdef MTX_SEQ_NOP_SKIP_EN
    logic [2:0] scan_from;
    logic       scan_found, scan_ill;
    logic [1:0] scan_idx;

    assign scan_from = (state_q == S_IDLE) ? 3'd0 : ({1'b0, slot_q} + 3'd1);

    // Find the next issuable slot at or after scan_from, noting illegal slots passed over.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = 2'd0;
        scan_ill   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((i >= int'(scan_from)) && !scan_found) begin
                if (exec_m[i]) begin
                    scan_found = 1'b1;
                    scan_idx   = 2'(i);
                end else if (ill_m[i]) begin
                    scan_ill = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wd_d    = wd_q;
        wd_inc  = {1'b0, wd_q} + 1'b1;
        set_inv = 1'b0;
        set_to  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MTX_SEQ_NOP_SKIP_EN
                    slot_d  = scan_idx;
                    state_d = scan_found ? S_ISSUE : S_DONE;
                    set_inv = scan_ill;
`else
                    slot_d  = 2'd0;
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (exec_m[slot_q]) begin
                    if (op_ready) begin
                        state_d = S_WAIT;
                        wd_d    = '0;
                    end
                end else begin
                    set_inv = ill_m[slot_q];
                    if (slot_q == 2'd3) state_d = S_DONE;
                    else                slot_d  = slot_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (exec_done) begin
`ifdef MTX_SEQ_NOP_SKIP_EN
                    slot_d  = scan_idx;
                    state_d = scan_found ? S_ISSUE : S_DONE;
                    set_inv = scan_ill;
`else
                    if (slot_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                        state_d = S_ISSUE;
                    end
`endif
                end else if (TIMEOUT != 0) begin
                    // exec_done is tested first, so it wins a tie with the watchdog.
                    if (wd_inc == WD_LIM) begin
                        set_to  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wd_d = wd_inc[WD_W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        op_valid_d    = (state_d == S_ISSUE) && exec_m[slot_d];
        op_d          = op_valid_d ? slot_op[slot_d] : OP_NOP;
        op_slot_d     = slot_d;
        bundle_done_d = (state_d == S_DONE);
        err_inv_d     = set_inv | (err_inv_q & ~err_clr);
        err_to_d      = set_to  | (err_to_q  & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            slot_q        <= 2'd0;
            bundle_q      <= '0;
            wd_q          <= '0;
            op_valid_q    <= 1'b0;
            op_q          <= OP_NOP;
            op_slot_q     <= 2'd0;
            bundle_done_q <= 1'b0;
            err_inv_q     <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            bundle_q      <= bundle_d;
            wd_q          <= wd_d;
            op_valid_q    <= op_valid_d;
            op_q          <= op_d;
            op_slot_q     <= op_slot_d;
            bundle_done_q <= bundle_done_d;
            err_inv_q     <= err_inv_d;
            err_to_q      <= err_to_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign op          = op_q;
    assign op_slot     = op_slot_q;
    assign bundle_done = bundle_done_q;
    assign err_inv     = err_inv_q;
    assign err_to      = err_to_q;

endmodule

// File: tb/tb_mtx_vliw_seq.sv
// Directed self-checking bench for mtx_vliw_seq (watchdog TIMEOUT=4).
module tb_mtx_vliw_seq;
    logic        clk = 1'b0;
    logic        rst, inst_valid, inst_ready, op_valid, op_ready;
    logic [19:0] inst;
    logic [4:0]  op;
    logic [1:0]  op_slot;
    logic        exec_done, bundle_done, busy, err_inv, err_to, err_clr;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MTX_SEQ_NOP_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    always #5 clk = ~clk;

    mtx_vliw_seq #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_slot(op_slot),
        .exec_done(exec_done), .bundle_done(bundle_done), .busy(busy),
        .err_inv(err_inv), .err_to(err_to), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the most recent run_bundle call.
    int         iss_n, bd_t, stall_n;
    int         iss_t [4];
    logic [4:0] iss_op [4];
    logic [1:0] iss_slot [4];
    logic [4:0] st_op;
    logic [1:0] st_slot;
    logic       saw_1f, stall_bad, bd_err_to;

    // Offer bundle b at cycle T (the current cycle), hold off op_ready for the first
    // 'stall' cycles an op is presented, and pulse exec_done 'lat' cycles after each
    // accept (lat <= 0: never). Offsets recorded relative to T.
    task automatic run_bundle(input logic [19:0] b, input int stall, input int lat);
        int pend;
        pend = -1;
        iss_n = 0; bd_t = -1; stall_n = 0; saw_1f = 1'b0; stall_bad = 1'b0; bd_err_to = 1'b0;
        st_op = '0; st_slot = '0;
        chk("accept_ready", inst_ready, 1);
        inst = b; inst_valid = 1'b1; op_ready = (stall == 0); exec_done = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            inst_valid = 1'b0;
            exec_done  = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    exec_done = 1'b1;
                    pend = -1;
                end
            end
            if (op == 5'h1F) saw_1f = 1'b1;
            if (op_valid) begin
                if (stall_n < stall) begin
                    if (stall_n == 0) begin
                        st_op = op; st_slot = op_slot;
                    end else if (op !== st_op || op_slot !== st_slot) begin
                        stall_bad = 1'b1;
                    end
                    stall_n++;
                    op_ready = 1'b0;
                end else begin
                    op_ready = 1'b1;
                    if (iss_n < 4) begin
                        iss_t[iss_n] = k; iss_op[iss_n] = op; iss_slot[iss_n] = op_slot;
                    end
                    iss_n++;
                    if (lat > 0) pend = lat;
                end
            end else begin
                op_ready = (stall_n >= stall);
            end
            if (bundle_done) begin
                bd_t = k;
                bd_err_to = err_to;
                break;
            end
        end
        exec_done = 1'b0;
        op_ready  = 1'b1;
        $display("bundle 0x%05h: %0d ops issued, bundle_done at T+%0d", b, iss_n, bd_t);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = '0; op_ready = 1'b1; exec_done = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op", op, 0);
        chk("rst_op_slot", op_slot, 0);
        chk("rst_bundle_done", bundle_done, 0);
        chk("rst_err_inv", err_inv, 0);
        chk("rst_err_to", err_to, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", inst_ready, 1);

        // Basic: VADD_01, NOP, VRELU, MVMUL
        run_bundle(20'h10281, 0, 1);
        chk("basic_n", iss_n, 3);
        chk("basic_t0", iss_t[0], 1);
        chk("basic_t1", iss_t[1], SKIP ? 3 : 4);
        chk("basic_t2", iss_t[2], SKIP ? 5 : 6);
        chk("basic_s0", iss_slot[0], 0);
        chk("basic_s1", iss_slot[1], 2);
        chk("basic_s2", iss_slot[2], 3);
        chk("basic_op0", iss_op[0], 5'h02);
        chk("basic_op1", iss_op[1], 5'h14);
        chk("basic_op2", iss_op[2], 5'h01);
        chk("basic_bd", bd_t, SKIP ? 7 : 8);
        chk("basic_done_ready", inst_ready, 0);
        @(negedge clk);
        chk("basic_idle_ready", inst_ready, 1);
        chk("basic_idle_busy", busy, 0);
        chk("basic_err_inv", err_inv, 0);

        // Illegal opcode in slot 1
        run_bundle(20'h87E10, 0, 1);
        chk("ill_saw_1f", saw_1f, 0);
        chk("ill_n", iss_n, 3);
        chk("ill_s1", iss_slot[1], 2);
        chk("ill_s2", iss_slot[2], 3);
        chk("ill_op1", iss_op[1], 5'h10);
        chk("ill_bd", bd_t, SKIP ? 7 : 8);
        @(negedge clk);
        chk("ill_err_inv", err_inv, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ill_err_clr", err_inv, 0);

        // Backpressure on slot 0 = LD_V0
        run_bundle(20'h40000, 3, 1);
        chk("bp_stall_n", stall_n, 3);
        chk("bp_stable", stall_bad, 0);
        chk("bp_op", st_op, 5'h08);
        chk("bp_slot", st_slot, 0);
        chk("bp_accept_t", iss_t[0], 4);
        chk("bp_n", iss_n, 1);
        chk("bp_bd", bd_t, SKIP ? 6 : 9);
        @(negedge clk);

        // Watchdog expiry
        run_bundle(20'h84210, 0, -1);
        chk("wd_n", iss_n, 1);
        chk("wd_bd", bd_t, 6);
        chk("wd_err_to_at_done", bd_err_to, 1);
        @(negedge clk);
        chk("wd_ready_after", inst_ready, 1);
        chk("wd_err_to_sticky", err_to, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("wd_err_clr", err_to, 0);

        // exec_done on the same cycle the watchdog would fire
        run_bundle(20'h80000, 0, 4);
        chk("wd_tie_n", iss_n, 1);
        chk("wd_tie_bd", bd_t, SKIP ? 6 : 9);
        chk("wd_tie_err_to", bd_err_to, 0);
        @(negedge clk);

        // Stray completion in IDLE and ISSUE
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_bd", bundle_done, 0);
        inst = 20'h40000; inst_valid = 1'b1; op_ready = 1'b0;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("stray_issue_valid", op_valid, 1);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("stray_still_issue", op_valid, 1);
        chk("stray_op", op, 5'h08);
        chk("stray_bd", bundle_done, 0);
        op_ready = 1'b1;
        @(negedge clk);
        chk("stray_wait", op_valid, 0);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        chk("stray_drain", busy, 0);
        $display("stray completion sequence done");

        // Reset while waiting on slot 1
        inst = 20'h84210; inst_valid = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("rstmid_s0", op_slot, 0);
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("rstmid_s1_valid", op_valid, 1);
        chk("rstmid_s1", op_slot, 1);
        @(negedge clk);
        chk("rstmid_wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_op_valid", op_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", inst_ready, 0);
        chk("rstmid_bd", bundle_done, 0);
        chk("rstmid_op", op, 0);
        chk("rstmid_slot", op_slot, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_after", inst_ready, 1);
        chk("rstmid_no_bd", bundle_done, 0);
        $display("reset mid-bundle sequence done");
        run_bundle(20'h10281, 0, 1);
        chk("rstmid_new_bd", bd_t, SKIP ? 7 : 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
